spi_fb_rx_capture: RTL
======================

Name: spi_fb_rx_capture

Overview:
Receive-side capture stage directly downstream of the SPI feedback clock generator. It samples spi_miso on the selected edge of the delayed feedback clock spi_clk_fb while transfer_active is high. It deserialises one frame of RD_ADDR + WR_ADDR + DATA bits, splits the frame into fields, and presents it to the AXI register side through a one-entry valid/ready output buffer. It also reports aborted frames and overruns.

Parameters:
SPI_RD_ADDR_WIDTH, 4, width of the read-address field (top bits of the frame)
SPI_WR_ADDR_WIDTH, 4, width of the write-address field (middle bits)
SPI_DATA_WIDTH, 32, width of the data field (bottom bits)
SAMPLE_EDGE, 0, 0 = sample on rising edge of spi_clk_fb, 1 = sample on falling edge
MISO_SYNC_STAGES, 2, flop stages on spi_miso before sampling (minimum 1)

Ports:
sys_clk  in  1  system clock; all logic runs on its rising edge
reset  in  1  asynchronous, active-high reset
transfer_active  in  1  frame window; same signal that drives the feedback clock generator
spi_clk_fb  in  1  delayed feedback SPI clock; generated synchronously to sys_clk, idles low
spi_miso  in  1  serial data from the slave, asynchronous
rx_ready  in  1  consumer accepts the buffered frame
ovf_clear  in  1  clears rx_overflow
rx_valid  out  1  buffered frame available
rx_rd_addr  out  SPI_RD_ADDR_WIDTH  captured read-address field
rx_wr_addr  out  SPI_WR_ADDR_WIDTH  captured write-address field
rx_data  out  SPI_DATA_WIDTH  captured data field
rx_abort  out  1  one-cycle pulse: frame ended before completion
rx_overflow  out  1  sticky: a completed frame was dropped because the buffer was full
rx_busy  out  1  high in SHIFT, LOAD and WAIT_END states

Behaviour:
- FRAME_W = SPI_RD_ADDR_WIDTH + SPI_WR_ADDR_WIDTH + SPI_DATA_WIDTH. The bit counter is $clog2(FRAME_W+1) bits wide.
- Reset (asynchronous): FSM goes to IDLE. All outputs, the shift register, the bit counter, fb_prev and the sync flops are cleared to 0.
- Edge detect:
  - fb_prev registers spi_clk_fb each cycle. fb_prev is forced to 0 while transfer_active is low.
  - rise = spi_clk_fb & ~fb_prev; fall = ~spi_clk_fb & fb_prev.
  - samp is rise when SAMPLE_EDGE=0 and fall when SAMPLE_EDGE=1.
  - spi_clk_fb is not synchronised, because it comes from the same clock domain.
- MISO passes through MISO_SYNC_STAGES flops. The sampled bit is the last sync stage in the samp cycle. Sync latency is compensated by the generator's SPI_CLK_DELAY setting, not here.
- Frame bit order is MSB first: frame[FRAME_W-1 -: RD] = rd_addr, next WR bits = wr_addr, low DATA bits = data.
- FSM states:
  - IDLE: when transfer_active is high, go to SHIFT. Clear the bit counter and the shift register.
  - SHIFT:
    - On samp: shift = {shift[FRAME_W-2:0], miso_s} and increment the counter.
    - On samp with counter == FRAME_W-1: go to LOAD.
    - If transfer_active is low before completion: go to IDLE, pulse rx_abort for 1 cycle, rx_valid unaffected. This has priority over a simultaneous samp.
  - LOAD (1 cycle), then go to WAIT_END:
    - If the buffer is empty, or rx_valid & rx_ready in this same cycle: write all fields; rx_valid = 1 from the next cycle.
    - Otherwise: drop the new frame, keep the old buffer contents, set rx_overflow.
  - WAIT_END: samp edges are ignored. Go to IDLE when transfer_active is low.
- Latency: rx_valid rises 2 sys_clk cycles after the cycle in which the final samp is detected.
- Output handshake:
  - rx_valid stays high and the field outputs stay stable until rx_valid & rx_ready. rx_valid then drops the next cycle unless a LOAD refills it in the same cycle.
  - rx_ready while rx_valid=0 is ignored.
- rx_overflow: set-dominant over ovf_clear in the same cycle; otherwise ovf_clear clears it.
- A reset mid-frame discards the partial frame with no rx_abort pulse.
- transfer_active re-asserted while in WAIT_END does not start a new frame until the FSM has passed through IDLE (i.e. transfer_active must be low for at least 1 cycle).

Test Plan:
1. Defaults, SAMPLE_EDGE=0, SCALE=2: shift rd=0xA, wr=0x5, data=0xDEADBEEF (40 bits) -> rx_rd_addr=0xA, rx_wr_addr=0x5, rx_data=0xDEADBEEF; rx_valid high exactly 2 cycles after the 40th rising edge; rx_abort=0.
2. rx_ready held low; complete two back-to-back frames 0x...00000001 then 0x...00000002 -> rx_data stays 0x00000001, rx_overflow=1; ovf_clear pulse -> rx_overflow=0.
3. Drop transfer_active after 17 sampled bits -> rx_abort is a single 1-cycle pulse, rx_valid stays 0, FSM returns to IDLE; the next full frame captures correctly.
4. rx_ready high in the same cycle as LOAD while the buffer holds frame A -> frame B is loaded, rx_valid stays high continuously, rx_overflow=0.
5. SAMPLE_EDGE=1, spi_miso changing only on rising edges -> capture matches the expected frame 0x3,0xC,0x12345678.
6. Assert reset at bit 20 -> all outputs 0 asynchronously, rx_abort not pulsed; after reset, frame 0xF,0xF,0xFFFFFFFF captures correctly.

Source files
------------

// File: rtl/spi_fb_rx_capture.sv
// Receive capture for the SPI feedback clock path: samples MISO on a feedback-clock edge,
// deserialises one RD_ADDR/WR_ADDR/DATA frame and hands it over through a one-entry buffer.
module spi_fb_rx_capture #(
  parameter int unsigned SPI_RD_ADDR_WIDTH = 4,
  parameter int unsigned SPI_WR_ADDR_WIDTH = 4,
  parameter int unsigned SPI_DATA_WIDTH    = 32,
  parameter int unsigned SAMPLE_EDGE       = 0,
  parameter int unsigned MISO_SYNC_STAGES  = 2
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         transfer_active,
  input  logic                         spi_clk_fb,
  input  logic                         spi_miso,
  input  logic                         rx_ready,
  input  logic                         ovf_clear,
  output logic                         rx_valid,
  output logic [SPI_RD_ADDR_WIDTH-1:0] rx_rd_addr,
  output logic [SPI_WR_ADDR_WIDTH-1:0] rx_wr_addr,
  output logic [SPI_DATA_WIDTH-1:0]    rx_data,
  output logic                         rx_abort,
  output logic                         rx_overflow,
  output logic                         rx_busy
);

  localparam int unsigned FRAME_W = SPI_RD_ADDR_WIDTH + SPI_WR_ADDR_WIDTH + SPI_DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StLoad, StWaitEnd} state_e;

  state_e                      state_q;
  logic                        fb_prev_q;
  logic [MISO_SYNC_STAGES-1:0] miso_sync_q;
  logic [FRAME_W-1:0]          shift_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        rise, fall, samp, miso_s;

  // The feedback clock is generated from sys_clk, so it is edge-detected without synchronisers.
  assign rise    = spi_clk_fb & ~fb_prev_q;
  assign fall    = ~spi_clk_fb & fb_prev_q;
  assign samp    = (SAMPLE_EDGE == 0) ? rise : fall;
  assign miso_s  = miso_sync_q[MISO_SYNC_STAGES-1];
  assign rx_busy = (state_q != StIdle);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fb_prev_q   <= 1'b0;
      miso_sync_q <= '0;
    end else begin
      fb_prev_q      <= transfer_active & spi_clk_fb;
      miso_sync_q[0] <= spi_miso;
      for (int i = 1; i < int'(MISO_SYNC_STAGES); i++) begin
        miso_sync_q[i] <= miso_sync_q[i-1];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_valid    <= 1'b0;
      rx_rd_addr  <= '0;
      rx_wr_addr  <= '0;
      rx_data     <= '0;
      rx_abort    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_abort <= 1'b0;
      if (ovf_clear) rx_overflow <= 1'b0;
      // Consumption; a LOAD in the same cycle overrides this below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q   <= '0;
          shift_q <= '0;
          if (transfer_active) state_q <= StShift;
        end
        StShift: begin
          if (!transfer_active) begin
            state_q  <= StIdle;
            rx_abort <= 1'b1;
          end else if (samp) begin
            shift_q <= {shift_q[FRAME_W-2:0], miso_s};
            cnt_q   <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BIT) state_q <= StLoad;
          end
        end
        StLoad: begin
          state_q <= StWaitEnd;
          if (!rx_valid || rx_ready) begin
            rx_rd_addr <= shift_q[FRAME_W-1 -: SPI_RD_ADDR_WIDTH];
            rx_wr_addr <= shift_q[SPI_DATA_WIDTH+SPI_WR_ADDR_WIDTH-1 -: SPI_WR_ADDR_WIDTH];
            rx_data    <= shift_q[SPI_DATA_WIDTH-1:0];
            rx_valid   <= 1'b1;
          end else begin
            rx_overflow <= 1'b1;
          end
        end
        StWaitEnd: begin
          if (!transfer_active) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
